prog_loader: RTL and testbench

UART program loader that sits directly upstream of the 8-bit multi-cycle CPU. It receives a framed program image over a serial line and writes it byte-by-byte into the CPU's 256×8 unified memory starting at address 0. While a load is in progress it holds the CPU. After a verified load it releases the CPU, which then restarts at PC=0.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_uart_rx.sv | 104 ++++++++++
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the UART program loader.
//   ld_state_t      loader FSM encoding (L_IDLE, L_DATA, L_CSUM, L_ERR)
//   rx_state_t      receiver FSM encoding (RX_IDLE, RX_START, RX_DATA, RX_STOP)
//   LED_ADDR        last CPU memory address (LED register)
//   clks_per_bit()  system clocks per serial bit, truncated
package prog_loader_pkg;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_DATA = 2'd1,
    L_CSUM = 2'd2,
    L_ERR  = 2'd3
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] LED_ADDR = 8'hFF;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// uart_rx_8n1: 8N1 serial receiver with 2-FF input synchronizer.
// Ports:
//   clk, rst      system clock, async active-high reset
//   rx            raw serial input, idle high
//   rx_busy       receiver not idle (only with PROG_LOADER_TIMEOUT_EN)
//   rx_data       received byte, valid while rx_valid is high
//   rx_valid      one-cycle strobe: stop bit sampled high
//   rx_ferr       one-cycle strobe: stop bit sampled low
// States:
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | timing to mid start bit, rejecting false starts
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling the stop bit
module uart_rx_8n1
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
`ifdef PROG_LOADER_TIMEOUT_EN
  output logic       rx_busy,
`endif
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam logic [15:0] T_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] T_HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta, rx_sync, rx_prev;
  rx_state_t   state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        sample;

  assign sample  = (timer == 16'd0);
  assign rx_data = shreg;
  // Strobes decode straight from registered state so the loader can
  // act on the stop sample at the very next edge.
  assign rx_valid = (state == RX_STOP) && sample && rx_sync;
  assign rx_ferr  = (state == RX_STOP) && sample && !rx_sync;
`ifdef PROG_LOADER_TIMEOUT_EN
  assign rx_busy = (state != RX_IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      timer   <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      if (!sample) timer <= timer - 16'd1;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            timer <= T_HALF;
          end
        end
        RX_START: begin
          if (sample) begin
            if (rx_sync) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              timer   <= T_FULL;
              bit_idx <= 3'd0;
            end
          end
        end
        RX_DATA: begin
          if (sample) begin
            shreg   <= {rx_sync, shreg[7:1]};
            timer   <= T_FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (sample) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image (LEN, N data bytes, CSUM)
// over 8N1 serial and writes it into CPU memory from address 0, holding
// the CPU while loading.
// Ports:
//   CLK_12MHz   system clock
//   Reset       async active-high reset
//   uart_rx     serial input, idle high
//   mem_we      one-cycle memory write strobe
//   mem_addr    write address
//   mem_wdata   write data
//   cpu_hold    CPU must stay stalled
//   load_done   one-cycle pulse on a verified load
//   load_err    sticky error, cleared by the next LEN byte
//   byte_count  data bytes written in current/last frame (wraps at 256)
// Build option: PROG_LOADER_TIMEOUT_EN enables the inter-byte gap timeout.
// States:
//   L_IDLE | waiting for LEN; CPU runs the resident image
//   L_DATA | writing data bytes to memory
//   L_CSUM | waiting for the checksum byte
//   L_ERR  | failed load; CPU held, next good byte is a new LEN
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic       CLK_12MHz,
  input  logic       Reset,
  input  logic       uart_rx,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err,
  output logic [7:0] byte_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;
  ld_state_t  state;
  logic [8:0] remaining;
  logic [7:0] addr_cnt;
  logic [7:0] csum;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  logic        rx_busy;
  logic [31:0] gap_cnt;
`endif

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (CLK_12MHz),
    .rst      (Reset),
    .rx       (uart_rx),
`ifdef PROG_LOADER_TIMEOUT_EN
    .rx_busy  (rx_busy),
`endif
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  always_ff @(posedge CLK_12MHz or posedge Reset) begin
    if (Reset) begin
      state      <= L_IDLE;
      remaining  <= 9'd0;
      addr_cnt   <= 8'd0;
      csum       <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 8'd0;
      mem_wdata  <= 8'd0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= 8'd0;
`ifdef PROG_LOADER_TIMEOUT_EN
      gap_cnt    <= 32'd0;
`endif
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        // A framing error while idle or failed is simply dropped.
        L_IDLE, L_ERR: begin
          if (rx_valid) begin
            remaining  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            addr_cnt   <= 8'd0;
            csum       <= 8'd0;
            byte_count <= 8'd0;
            load_err   <= 1'b0;
            cpu_hold   <= 1'b1;
            state      <= L_DATA;
          end
        end
        L_DATA: begin
          if (rx_valid) begin
            mem_we     <= 1'b1;
            mem_addr   <= addr_cnt;
            mem_wdata  <= rx_data;
            // Wraps to 0 only after the 256th byte of a LEN=0 frame.
            addr_cnt   <= (addr_cnt == LED_ADDR) ? 8'd0 : addr_cnt + 8'd1;
            csum       <= csum + rx_data;
            byte_count <= byte_count + 8'd1;
            remaining  <= remaining - 9'd1;
            if (remaining == 9'd1) state <= L_CSUM;
          end else if (rx_ferr) begin
            load_err <= 1'b1;
            state    <= L_ERR;
          end
        end
        L_CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
              state     <= L_IDLE;
            end else begin
              load_err <= 1'b1;
              state    <= L_ERR;
            end
          end else if (rx_ferr) begin
            load_err <= 1'b1;
            state    <= L_ERR;
          end
        end
        default: state <= L_IDLE;
      endcase
`ifdef PROG_LOADER_TIMEOUT_EN
      // Gap counter reloads while a byte is in flight and runs down while
      // the line is idle mid-frame; terminal count aborts the load.
      if (rx_busy || rx_valid || !(state == L_DATA || state == L_CSUM)) begin
        gap_cnt <= 32'(GAP_LIMIT - 1);
      end else if (gap_cnt != 32'd0) begin
        gap_cnt <= gap_cnt - 32'd1;
      end else begin
        load_err <= 1'b1;
        state    <= L_ERR;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 1500000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       mem_we, cpu_hold, load_done, load_err;
  logic [7:0] mem_addr, mem_wdata, byte_count;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int dones = 0;
  logic [7:0] last_addr = 8'h00;
  logic [15:0] exp_q[$];
  logic [7:0]  frame_data[$];
  logic [7:0]  exp_addr;

  prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(64)) dut (
    .CLK_12MHz  (clk),
    .Reset      (rst),
    .uart_rx    (rx),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Write / done monitor against the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [15:0] exp;
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none", mem_addr, mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        assert ({mem_addr, mem_wdata} === exp) else begin
          failures++;
          $error("FAIL write observed=%0h expected=%0h", {mem_addr, mem_wdata}, exp);
        end
      end
      last_addr = mem_addr;
    end
    if (!rst && load_done) begin
      dones++;
      checks++;
      assert (cpu_hold === 1'b0) else begin
        failures++;
        $error("FAIL hold_at_done observed=%0b expected=0", cpu_hold);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] sum_data();
    logic [7:0] s = 8'd0;
    foreach (frame_data[i]) s = s + frame_data[i];
    return s;
  endfunction

  task automatic send_frame(input logic [7:0] len, input logic [7:0] csum);
    send_byte(len, 1'b1);
    exp_addr = 8'd0;
    foreach (frame_data[i]) begin
      exp_q.push_back({exp_addr, frame_data[i]});
      exp_addr = exp_addr + 8'd1;
      send_byte(frame_data[i], 1'b1);
    end
    send_byte(csum, 1'b1);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},    32'(mem_we),     32'd0);
    chk({tag, "_addr"},  32'(mem_addr),   32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),   32'd0);
    chk({tag, "_done"},  32'(load_done),  32'd0);
    chk({tag, "_err"},   32'(load_err),   32'd0);
    chk({tag, "_bcnt"},  32'(byte_count), 32'd0);
  endtask

  initial begin
    int d;
    repeat (4) @(negedge clk);
    chk_idle_outputs("in_reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle_outputs("after_reset");

    // 0.4-bit glitch: false start, nothing received.
    rx = 1'b0;
    repeat ((CPB * 4) / 10) @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    chk_idle_outputs("glitch");
    chk("glitch_writes", 32'(writes), 32'd0);
    chk("glitch_state", 32'(dut.state), 32'(L_IDLE));

    // Good 3-byte frame.
    frame_data = '{8'hBF, 8'hF0, 8'h90};
    send_frame(8'd3, 8'h3F);
    chk("f1_done", 32'(dones), 32'd1);
    chk("f1_hold", 32'(cpu_hold), 32'd0);
    chk("f1_err", 32'(load_err), 32'd0);
    chk("f1_bcnt", 32'(byte_count), 32'd3);
    chk("f1_writes", 32'(writes), 32'd3);
    chk("f1_q", 32'(exp_q.size()), 32'd0);

    // Same frame, bad checksum.
    send_frame(8'd3, 8'h40);
    chk("f2_done", 32'(dones), 32'd1);
    chk("f2_hold", 32'(cpu_hold), 32'd1);
    chk("f2_err", 32'(load_err), 32'd1);
    chk("f2_writes", 32'(writes), 32'd6);
    chk("f2_state", 32'(dut.state), 32'(L_ERR));

    // Recovery frame clears load_err.
    frame_data = '{8'h11, 8'h22};
    send_frame(8'd2, sum_data());
    chk("f3_done", 32'(dones), 32'd2);
    chk("f3_hold", 32'(cpu_hold), 32'd0);
    chk("f3_err", 32'(load_err), 32'd0);
    chk("f3_bcnt", 32'(byte_count), 32'd2);

    // Stop bit low on the second data byte.
    send_byte(8'd3, 1'b1);
    exp_q.push_back({8'h00, 8'hA5});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("ferr_writes", 32'(writes), 32'd9);
    chk("ferr_err", 32'(load_err), 32'd1);
    chk("ferr_hold", 32'(cpu_hold), 32'd1);
    chk("ferr_state", 32'(dut.state), 32'(L_ERR));
    chk("ferr_bcnt", 32'(byte_count), 32'd1);

    // LEN=0: 256 bytes, value = index; wraps address once.
    frame_data.delete();
    for (int i = 0; i < 256; i++) frame_data.push_back(8'(i));
    d = dones;
    send_frame(8'd0, 8'h80);
    chk("f256_done", 32'(dones), 32'(d + 1));
    chk("f256_last_addr", 32'(last_addr), 32'hFF);
    chk("f256_bcnt", 32'(byte_count), 32'd0);
    chk("f256_hold", 32'(cpu_hold), 32'd0);
    chk("f256_err", 32'(load_err), 32'd0);
    chk("f256_writes", 32'(writes), 32'd265);
    chk("f256_q", 32'(exp_q.size()), 32'd0);

    // LEN=4, two data bytes, then 70 bit-times of idle line.
    send_byte(8'd4, 1'b1);
    exp_q.push_back({8'h00, 8'h01});
    send_byte(8'h01, 1'b1);
    exp_q.push_back({8'h01, 8'h02});
    send_byte(8'h02, 1'b1);
    repeat (70 * CPB) @(negedge clk);
    chk("gap_hold", 32'(cpu_hold), 32'd1);
    chk("gap_bcnt", 32'(byte_count), 32'd2);
    chk("gap_q", 32'(exp_q.size()), 32'd0);
`ifdef PROG_LOADER_TIMEOUT_EN
    chk("gap_err", 32'(load_err), 32'd1);
    chk("gap_state", 32'(dut.state), 32'(L_ERR));
`else
    chk("gap_err", 32'(load_err), 32'd0);
    chk("gap_state", 32'(dut.state), 32'(L_DATA));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
